// File: rtl/sequencer_mc.sv
// sequencer_mc: control sequencer for the tiny CPU core.
// Steps each instruction through fetch, decode, execute and writeback phases.
// Supports multi-beat fetch, a configurable ALU dwell, a wait-state watchdog
// with a fault trap, and halt/single-step debug control.
// Optional feature: define SEQ_RETIRE_COUNTER_EN to build the 32-bit
// retired-instruction counter. Without it, retire_count_out is tied to zero.
module sequencer_mc #(
  parameter int FETCH_WORDS = 1,
  parameter int ALU_CYCLES  = 1,
  parameter int TIMEOUT_W   = 8
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        mem_busy_in,
  input  logic        inst_fetch_done_in,
  input  logic        data_read_done_in,
  input  logic [1:0]  inst_type_in,
  input  logic [1:0]  imm_type_in,
  input  logic        halt_req_in,
  input  logic        step_in,
  input  logic        fault_clear_in,
  output logic [3:0]  seq_state_out,
  output logic [1:0]  fetch_beat_out,
  output logic        retire_out,
  output logic        halted_out,
  output logic        fault_out,
  output logic [31:0] retire_count_out
);

  typedef enum logic [3:0] {
    S_FETCH          = 4'd0,
    S_FETCH_WAIT     = 4'd1,
    S_DECODE         = 4'd2,
    S_LOAD_MEM       = 4'd3,
    S_LOAD_MEM_WAIT  = 4'd4,
    S_STORE_MEM      = 4'd5,
    S_STORE_MEM_WAIT = 4'd6,
    S_ALU_EXEC       = 4'd7,
    S_UPDATE_PC      = 4'd8,
    S_HALT           = 4'd9,
    S_FAULT          = 4'd10
  } state_t;

  // Last fetch beat index, last ALU dwell count, and the watchdog count at
  // which a further idle wait cycle would reach the limit (2^TIMEOUT_W-1).
  localparam logic [1:0]           BEAT_LAST = 2'(FETCH_WORDS - 1);
  localparam logic [2:0]           ALU_LAST  = 3'(ALU_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = ~TIMEOUT_W'(1);

  state_t               r_state;
  state_t               w_next_state;
  logic [1:0]           r_beat;
  logic [1:0]           w_next_beat;
  logic [TIMEOUT_W-1:0] r_wait;
  logic [TIMEOUT_W-1:0] w_next_wait;
  logic [2:0]           r_alu;
  logic [2:0]           w_next_alu;
  logic                 w_in_wait;
  logic                 w_wait_exit;

  // Next-state logic. Counters fall back to zero outside their own states,
  // so they are always clear on entry. The watchdog check comes last and
  // only fires when the wait state has no exit this cycle, so an exit that
  // arrives on the limit cycle still wins.
  always_comb begin
    w_next_state = r_state;
    w_next_beat  = r_beat;
    w_next_wait  = '0;
    w_next_alu   = '0;
    w_in_wait    = 1'b0;
    w_wait_exit  = 1'b0;
    case (r_state)
      S_FETCH: w_next_state = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        w_in_wait   = 1'b1;
        w_wait_exit = inst_fetch_done_in;
        if (inst_fetch_done_in) begin
          if (r_beat < BEAT_LAST) begin
            w_next_beat  = r_beat + 2'd1;
            w_next_state = S_FETCH;
          end else begin
            w_next_beat  = 2'd0;
            w_next_state = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        case (inst_type_in)
          2'b00, 2'b01: w_next_state = S_UPDATE_PC;
          2'b10:        w_next_state = S_ALU_EXEC;
          2'b11: begin
            if (imm_type_in[1])      w_next_state = S_UPDATE_PC;
            else if (imm_type_in[0]) w_next_state = S_STORE_MEM;
            else                     w_next_state = S_LOAD_MEM;
          end
        endcase
      end
      S_LOAD_MEM: w_next_state = S_LOAD_MEM_WAIT;
      S_LOAD_MEM_WAIT: begin
        w_in_wait   = 1'b1;
        w_wait_exit = data_read_done_in;
        if (data_read_done_in) w_next_state = S_UPDATE_PC;
      end
      S_STORE_MEM: w_next_state = S_STORE_MEM_WAIT;
      S_STORE_MEM_WAIT: begin
        w_in_wait   = 1'b1;
        w_wait_exit = ~mem_busy_in;
        if (!mem_busy_in) w_next_state = S_UPDATE_PC;
      end
      S_ALU_EXEC: begin
        if (r_alu == ALU_LAST) w_next_state = S_UPDATE_PC;
        else                   w_next_alu   = r_alu + 3'd1;
      end
      S_UPDATE_PC: w_next_state = halt_req_in ? S_HALT : S_FETCH;
      S_HALT: begin
        if (!halt_req_in || step_in) w_next_state = S_FETCH;
      end
      S_FAULT: begin
        if (fault_clear_in) begin
          w_next_state = S_FETCH;
          w_next_beat  = 2'd0;
        end
      end
      default: w_next_state = S_FETCH;
    endcase
    if (w_in_wait && !w_wait_exit) begin
      if (r_wait == WAIT_LAST) w_next_state = S_FAULT;
      else                     w_next_wait  = r_wait + 1'b1;
    end
  end

  // State and counter registers; reset abandons any instruction in flight.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state <= S_FETCH;
      r_beat  <= 2'd0;
      r_wait  <= '0;
      r_alu   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_beat  <= w_next_beat;
      r_wait  <= w_next_wait;
      r_alu   <= w_next_alu;
    end
  end

  assign seq_state_out  = r_state;
  assign fetch_beat_out = r_beat;
  assign retire_out     = (r_state == S_UPDATE_PC);
  assign halted_out     = (r_state == S_HALT);
  assign fault_out      = (r_state == S_FAULT);

`ifdef SEQ_RETIRE_COUNTER_EN
  logic [31:0] r_retire_count;

  // Count every UPDATE_PC cycle, wrapping naturally; only reset clears it.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) r_retire_count <= 32'd0;
    else if (r_state == S_UPDATE_PC) r_retire_count <= r_retire_count + 32'd1;
  end

  assign retire_count_out = r_retire_count;
`else
  assign retire_count_out = 32'd0;
`endif

endmodule

// File: tb/tb_sequencer_mc.sv
// tb_sequencer_mc: self-checking bench for sequencer_mc.
// Instructions are described at transaction level (class, fetch delays,
// memory delay, halt behaviour) and expanded into an expected per-cycle
// state trace together with the inputs that produce it. Don't-care inputs
// are randomised on every cycle.
module tb_sequencer_mc;

  localparam int FW = 2;
  localparam int AC = 3;
  localparam int TW = 3;
  localparam int TL = (1 << TW) - 1;

  logic        clk_in;
  logic        reset_in;
  logic        mem_busy_in;
  logic        inst_fetch_done_in;
  logic        data_read_done_in;
  logic [1:0]  inst_type_in;
  logic [1:0]  imm_type_in;
  logic        halt_req_in;
  logic        step_in;
  logic        fault_clear_in;
  logic [3:0]  seq_state_out;
  logic [1:0]  fetch_beat_out;
  logic        retire_out;
  logic        halted_out;
  logic        fault_out;
  logic [31:0] retire_count_out;

  typedef struct {
    logic [3:0] st;
    logic [1:0] beat;
    logic       done;
    logic       data;
    logic       busy;
    logic [1:0] ity;
    logic [1:0] imm;
    logic       halt;
    logic       step;
    logic       clr;
  } cyc_t;

  typedef struct {
    logic [3:0]  st;
    logic [1:0]  beat;
    logic        ret;
    logic        hlt;
    logic        flt;
    logic [31:0] cnt;
  } obs_t;

  cyc_t tr[$];
  obs_t ob[$];
  int   total = 0;
  int   bad = 0;
  int   retiredSoFar = 0;

  sequencer_mc #(
    .FETCH_WORDS(FW),
    .ALU_CYCLES (AC),
    .TIMEOUT_W  (TW)
  ) dut (
    .clk_in            (clk_in),
    .reset_in          (reset_in),
    .mem_busy_in       (mem_busy_in),
    .inst_fetch_done_in(inst_fetch_done_in),
    .data_read_done_in (data_read_done_in),
    .inst_type_in      (inst_type_in),
    .imm_type_in       (imm_type_in),
    .halt_req_in       (halt_req_in),
    .step_in           (step_in),
    .fault_clear_in    (fault_clear_in),
    .seq_state_out     (seq_state_out),
    .fetch_beat_out    (fetch_beat_out),
    .retire_out        (retire_out),
    .halted_out        (halted_out),
    .fault_out         (fault_out),
    .retire_count_out  (retire_count_out)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  function automatic int expCount();
`ifdef SEQ_RETIRE_COUNTER_EN
    return retiredSoFar;
`else
    return 0;
`endif
  endfunction

  // One expected cycle with every input randomised; callers pin the inputs
  // that matter in that state.
  function automatic cyc_t mk(input logic [3:0] st, input logic [1:0] beat);
    cyc_t c;
    c.st   = st;
    c.beat = beat;
    c.done = 1'($urandom_range(0, 1));
    c.data = 1'($urandom_range(0, 1));
    c.busy = 1'($urandom_range(0, 1));
    c.ity  = 2'($urandom_range(0, 3));
    c.imm  = 2'($urandom_range(0, 3));
    c.halt = 1'($urandom_range(0, 1));
    c.step = 1'($urandom_range(0, 1));
    c.clr  = 1'($urandom_range(0, 1));
    return c;
  endfunction

  // Wait state lasting d cycles (the exit arrives on cycle d). If d exceeds
  // the limit, the watchdog traps after TL idle cycles and FAULT is held
  // for a few cycles before fault_clear_in releases it.
  task automatic genWait(input logic [3:0] st, input logic [1:0] beat,
                         input int d, input int kind, output bit faulted);
    cyc_t c;
    int   n;
    n = (d > TL) ? TL : d;
    for (int k = 1; k <= n; k++) begin
      c = mk(st, beat);
      if (kind == 0)      c.done = (k == d);
      else if (kind == 1) c.data = (k == d);
      else                c.busy = !(k == d);
      tr.push_back(c);
    end
    faulted = (d > TL);
    if (faulted) begin
      n = $urandom_range(1, 3);
      for (int k = 1; k <= n; k++) begin
        c = mk(4'd10, beat);
        c.clr = (k == n);
        tr.push_back(c);
      end
    end
  endtask

  // Expand one instruction into expected cycles. haltMode: 0 none,
  // 1 halt then release, 2 halt then single-step.
  task automatic genInstr(input logic [1:0] ity, input logic [1:0] imm,
                          input int fd0, input int fd1, input int md,
                          input int haltMode);
    cyc_t c;
    bit   f;
    int   k;
    for (int b = 0; b < FW; b++) begin
      tr.push_back(mk(4'd0, 2'(b)));
      genWait(4'd1, 2'(b), (b == 0) ? fd0 : fd1, 0, f);
      if (f) return;
    end
    c = mk(4'd2, 2'd0);
    c.ity = ity;
    c.imm = imm;
    tr.push_back(c);
    if (ity == 2'b10) begin
      for (int j = 0; j < AC; j++) tr.push_back(mk(4'd7, 2'd0));
    end else if (ity == 2'b11 && imm == 2'b00) begin
      tr.push_back(mk(4'd3, 2'd0));
      genWait(4'd4, 2'd0, md, 1, f);
      if (f) return;
    end else if (ity == 2'b11 && imm == 2'b01) begin
      tr.push_back(mk(4'd5, 2'd0));
      genWait(4'd6, 2'd0, md, 2, f);
      if (f) return;
    end
    c = mk(4'd8, 2'd0);
    c.halt = (haltMode != 0);
    tr.push_back(c);
    if (haltMode != 0) begin
      k = $urandom_range(1, 3);
      for (int j = 1; j <= k; j++) begin
        c = mk(4'd9, 2'd0);
        if (haltMode == 1) begin
          c.halt = (j != k);
          if (j != k) c.step = 1'b0;
        end else begin
          c.halt = 1'b1;
          c.step = (j == k);
        end
        tr.push_back(c);
      end
    end
  endtask

  // Drive the trace one cycle at a time, recording outputs #1 after each edge.
  task automatic playTrace();
    obs_t o;
    ob.delete();
    foreach (tr[i]) begin
      o.st  = seq_state_out;
      o.beat = fetch_beat_out;
      o.ret = retire_out;
      o.hlt = halted_out;
      o.flt = fault_out;
      o.cnt = retire_count_out;
      ob.push_back(o);
      mem_busy_in        = tr[i].busy;
      inst_fetch_done_in = tr[i].done;
      data_read_done_in  = tr[i].data;
      inst_type_in       = tr[i].ity;
      imm_type_in        = tr[i].imm;
      halt_req_in        = tr[i].halt;
      step_in            = tr[i].step;
      fault_clear_in     = tr[i].clr;
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    mem_busy_in = 1'b0;
    inst_fetch_done_in = 1'b0;
    data_read_done_in = 1'b0;
    inst_type_in = 2'b00;
    imm_type_in = 2'b00;
    halt_req_in = 1'b0;
    step_in = 1'b0;
    fault_clear_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    total++; if (seq_state_out !== 4'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", seq_state_out); end
    total++; if (fetch_beat_out !== 2'd0) begin bad++; $display("[TB] FAIL reset_beat got=%0d want=0", fetch_beat_out); end
    total++; if (retire_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_retire got=%b want=0", retire_out); end
    total++; if (halted_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted got=%b want=0", halted_out); end
    total++; if (fault_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault got=%b want=0", fault_out); end
    total++; if (retire_count_out !== 32'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", retire_count_out); end
    reset_in = 1'b0;
    retiredSoFar = 0;
  endtask

  task automatic test_directed();
    tr.delete();
    genInstr(2'b10, 2'b00, 2, 2, 1, 0);
    genInstr(2'b11, 2'b00, 1, 1, 3, 0);
    genInstr(2'b11, 2'b01, 1, 1, 2, 0);
    genInstr(2'b11, 2'b10, 1, 1, 1, 0);
    genInstr(2'b01, 2'b00, 8, 1, 1, 0);
    genInstr(2'b00, 2'b00, 7, 7, 1, 0);
    genInstr(2'b00, 2'b00, 2, 9, 1, 0);
    genInstr(2'b11, 2'b00, 1, 1, 8, 0);
    genInstr(2'b11, 2'b01, 1, 1, 7, 0);
    genInstr(2'b10, 2'b00, 1, 1, 1, 2);
    genInstr(2'b00, 2'b00, 1, 1, 1, 1);
    playTrace();
    foreach (tr[i]) begin
      total++; if (ob[i].st !== tr[i].st) begin bad++; $display("[TB] FAIL dir_state cyc=%0d got=%0d want=%0d", i, ob[i].st, tr[i].st); end
      total++; if (ob[i].beat !== tr[i].beat) begin bad++; $display("[TB] FAIL dir_beat cyc=%0d got=%0d want=%0d", i, ob[i].beat, tr[i].beat); end
      total++; if (ob[i].ret !== (tr[i].st == 4'd8)) begin bad++; $display("[TB] FAIL dir_retire cyc=%0d got=%b", i, ob[i].ret); end
      total++; if (ob[i].hlt !== (tr[i].st == 4'd9)) begin bad++; $display("[TB] FAIL dir_halted cyc=%0d got=%b", i, ob[i].hlt); end
      total++; if (ob[i].flt !== (tr[i].st == 4'd10)) begin bad++; $display("[TB] FAIL dir_fault cyc=%0d got=%b", i, ob[i].flt); end
      total++; if (ob[i].cnt !== 32'(expCount())) begin bad++; $display("[TB] FAIL dir_count cyc=%0d got=%0d want=%0d", i, ob[i].cnt, expCount()); end
      if (tr[i].st == 4'd8) retiredSoFar++;
    end
  endtask

  task automatic test_random();
    int m;
    tr.delete();
    for (int n = 0; n < 40; n++) begin
      m = $urandom_range(0, 5);
      genInstr(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               $urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 9),
               (m < 4) ? 0 : m - 3);
    end
    playTrace();
    foreach (tr[i]) begin
      total++; if (ob[i].st !== tr[i].st) begin bad++; $display("[TB] FAIL rnd_state cyc=%0d got=%0d want=%0d", i, ob[i].st, tr[i].st); end
      total++; if (ob[i].beat !== tr[i].beat) begin bad++; $display("[TB] FAIL rnd_beat cyc=%0d got=%0d want=%0d", i, ob[i].beat, tr[i].beat); end
      total++; if (ob[i].ret !== (tr[i].st == 4'd8)) begin bad++; $display("[TB] FAIL rnd_retire cyc=%0d got=%b", i, ob[i].ret); end
      total++; if (ob[i].hlt !== (tr[i].st == 4'd9)) begin bad++; $display("[TB] FAIL rnd_halted cyc=%0d got=%b", i, ob[i].hlt); end
      total++; if (ob[i].flt !== (tr[i].st == 4'd10)) begin bad++; $display("[TB] FAIL rnd_fault cyc=%0d got=%b", i, ob[i].flt); end
      total++; if (ob[i].cnt !== 32'(expCount())) begin bad++; $display("[TB] FAIL rnd_count cyc=%0d got=%0d want=%0d", i, ob[i].cnt, expCount()); end
      if (tr[i].st == 4'd8) retiredSoFar++;
    end
  endtask

  task automatic test_async_reset();
    cyc_t c;
    bit   f;
    tr.delete();
    tr.push_back(mk(4'd0, 2'd0));
    genWait(4'd1, 2'd0, 1, 0, f);
    tr.push_back(mk(4'd0, 2'd1));
    genWait(4'd1, 2'd1, 1, 0, f);
    c = mk(4'd2, 2'd0);
    c.ity = 2'b11;
    c.imm = 2'b00;
    tr.push_back(c);
    tr.push_back(mk(4'd3, 2'd0));
    c = mk(4'd4, 2'd0);
    c.data = 1'b0;
    tr.push_back(c);
    tr.push_back(c);
    playTrace();
    total++; if (seq_state_out !== 4'd4) begin bad++; $display("[TB] FAIL ar_pre_state got=%0d want=4", seq_state_out); end
    #3;
    reset_in = 1'b1;
    #1;
    total++; if (seq_state_out !== 4'd0) begin bad++; $display("[TB] FAIL ar_state got=%0d want=0", seq_state_out); end
    total++; if ({retire_out, halted_out, fault_out} !== 3'b000) begin bad++; $display("[TB] FAIL ar_flags got=%b want=000", {retire_out, halted_out, fault_out}); end
    total++; if (retire_count_out !== 32'd0) begin bad++; $display("[TB] FAIL ar_count got=%0d want=0", retire_count_out); end
    @(posedge clk_in);
    #1;
    reset_in = 1'b0;
    retiredSoFar = 0;
  endtask

  task automatic test_retire_count();
    tr.delete();
    for (int n = 0; n < 5; n++) genInstr(2'b00, 2'b00, 1, 1, 1, 0);
    playTrace();
    retiredSoFar = 5;
    total++; if (retire_count_out !== 32'(expCount())) begin bad++; $display("[TB] FAIL retire_count got=%0d want=%0d", retire_count_out, expCount()); end
    total++; if (seq_state_out !== 4'd0) begin bad++; $display("[TB] FAIL rc_state got=%0d want=0", seq_state_out); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_async_reset();
    test_retire_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
